fp_issue_scoreboard: RTL and testbench

- Registered decode/issue stage for the RV32 core's FP extension: FADD.S, FMUL.S, FLT.S, FLW and FSW.
- Sits between the fetch/IR register and execute. Holds one decoded instruction in an output register under a valid/ready handshake.
- Tracks multi-cycle FP destination writes in a per-register scoreboard with programmable latencies.
- Stalls RAW and WAW hazards on the FP register file; non-FP instructions pass through with all FP flags low.

---
 rtl/fp_issue_scoreboard.sv | 260 ++++++++++++++++++++++++++
 tb/tb_fp_issue_scoreboard.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_issue_scoreboard.sv
// fp_issue_scoreboard: registered decode/issue stage for the RV32 FP subset
// (FADD.S, FMUL.S, FLT.S, FLW, FSW). Holds one decoded instruction under a
// valid/ready handshake and stalls RAW/WAW hazards against a per-register
// countdown scoreboard of in-flight FP destination writes.
module fp_issue_scoreboard #(
  parameter int NFREG    = 32,
  parameter int LAT_W    = 3,
  parameter int FADD_LAT = 3,
  parameter int FMUL_LAT = 4,
  parameter int FLW_LAT  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_ir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_ir,
  output logic             out_fcal,
  output logic [1:0]       out_fop,
  output logic             out_frd,
  output logic             out_frs1,
  output logic             out_frs2,
  output logic             out_regwrite,
  output logic             out_flw,
  output logic             out_fsw,
  output logic             out_illegal,
  output logic [NFREG-1:0] busy_vec,
  output logic [NFREG-1:0] done_vec
);

  localparam logic [6:0] OP_FP    = 7'b1010011;
  localparam logic [6:0] OP_LDFP  = 7'b0000111;
  localparam logic [6:0] OP_STFP  = 7'b0100111;

  localparam logic [1:0] FOP_ADD  = 2'b00;
  localparam logic [1:0] FOP_MUL  = 2'b01;
  localparam logic [1:0] FOP_LT   = 2'b10;
  localparam logic [1:0] FOP_NONE = 2'b11;

  // Instruction fields of the incoming word
  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic [4:0] w_rd;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;

  assign w_opcode = in_ir[6:0];
  assign w_rd     = in_ir[11:7];
  assign w_funct3 = in_ir[14:12];
  assign w_rs1    = in_ir[19:15];
  assign w_rs2    = in_ir[24:20];
  assign w_funct7 = in_ir[31:25];

  // Decoded flags of the incoming word
  logic       w_dec_fcal;
  logic [1:0] w_dec_fop;
  logic       w_dec_frd;
  logic       w_dec_frs1;
  logic       w_dec_frs2;
  logic       w_dec_regwrite;
  logic       w_dec_flw;
  logic       w_dec_fsw;
  logic       w_dec_illegal;

  // Held (output) register state
  logic             r_valid;
  logic [31:0]      r_ir;
  logic             r_fcal;
  logic [1:0]       r_fop;
  logic             r_frd;
  logic             r_frs1;
  logic             r_frs2;
  logic             r_regwrite;
  logic             r_flw;
  logic             r_fsw;
  logic             r_illegal;

  // Scoreboard countdowns, one per FP register
  logic [LAT_W-1:0] r_cnt [NFREG];

  logic             w_held_wr;
  logic [4:0]       w_held_rd;
  logic             w_raw;
  logic             w_waw;
  logic             w_hazard;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_out_fire;
  logic             w_load_en;
  logic [LAT_W-1:0] w_load_lat;
  logic [4:0]       w_load_rd;

  // Decode the incoming instruction into FP control flags
  always_comb begin
    w_dec_fcal     = 1'b0;
    w_dec_fop      = FOP_NONE;
    w_dec_frd      = 1'b0;
    w_dec_frs1     = 1'b0;
    w_dec_frs2     = 1'b0;
    w_dec_regwrite = 1'b0;
    w_dec_flw      = 1'b0;
    w_dec_fsw      = 1'b0;
    w_dec_illegal  = 1'b0;
    case (w_opcode)
      OP_FP: begin
        if (w_funct7 == 7'b0000000) begin
          w_dec_fcal     = 1'b1;
          w_dec_fop      = FOP_ADD;
          w_dec_frd      = 1'b1;
          w_dec_frs1     = 1'b1;
          w_dec_frs2     = 1'b1;
          w_dec_regwrite = 1'b1;
        end else if (w_funct7 == 7'b0001000) begin
          w_dec_fcal     = 1'b1;
          w_dec_fop      = FOP_MUL;
          w_dec_frd      = 1'b1;
          w_dec_frs1     = 1'b1;
          w_dec_frs2     = 1'b1;
          w_dec_regwrite = 1'b1;
        end else if (w_funct7 == 7'b1010000 && w_funct3 == 3'b001) begin
          w_dec_fop      = FOP_LT;
          w_dec_frs1     = 1'b1;
          w_dec_frs2     = 1'b1;
          w_dec_regwrite = 1'b1;
        end else begin
          w_dec_illegal  = 1'b1;
        end
      end
      OP_LDFP: begin
        if (w_funct3 == 3'b010) begin
          w_dec_flw      = 1'b1;
          w_dec_frd      = 1'b1;
          w_dec_regwrite = 1'b1;
        end else begin
          w_dec_illegal  = 1'b1;
        end
      end
      OP_STFP: begin
        if (w_funct3 == 3'b010) begin
          w_dec_fsw      = 1'b1;
          w_dec_frs2     = 1'b1;
        end else begin
          w_dec_illegal  = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // The held instruction is a pending FP write until it leaves the stage;
  // its rd is compared directly because it has not reached the scoreboard yet.
  assign w_held_wr = r_valid & r_frd;
  assign w_held_rd = r_ir[11:7];

  // Hazard detection of the current decode against scoreboard and held word
  always_comb begin
    w_raw = (w_dec_frs1 & (busy_vec[w_rs1] | (w_held_wr & (w_held_rd == w_rs1))))
          | (w_dec_frs2 & (busy_vec[w_rs2] | (w_held_wr & (w_held_rd == w_rs2))));
    w_waw = w_dec_frd & (busy_vec[w_rd] | (w_held_wr & (w_held_rd == w_rd)));
    w_hazard = w_raw | w_waw;
  end

  assign w_in_ready = ~flush & ~w_hazard & (~r_valid | out_ready);
  assign w_accept   = in_valid & w_in_ready;
  assign w_out_fire = r_valid & out_ready & ~flush;

  // Select which scoreboard entry (if any) the issuing instruction arms
  always_comb begin
    w_load_en  = 1'b0;
    w_load_lat = '0;
    w_load_rd  = r_ir[11:7];
    if (w_out_fire) begin
      if (r_fcal && r_fop == FOP_ADD) begin
        w_load_en  = 1'b1;
        w_load_lat = LAT_W'(FADD_LAT);
      end else if (r_fcal && r_fop == FOP_MUL) begin
        w_load_en  = 1'b1;
        w_load_lat = LAT_W'(FMUL_LAT);
      end else if (r_flw) begin
        w_load_en  = 1'b1;
        w_load_lat = LAT_W'(FLW_LAT);
      end
    end
  end

  // Output register: load on accept, empty on fire or flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_ir       <= '0;
      r_fcal     <= 1'b0;
      r_fop      <= FOP_NONE;
      r_frd      <= 1'b0;
      r_frs1     <= 1'b0;
      r_frs2     <= 1'b0;
      r_regwrite <= 1'b0;
      r_flw      <= 1'b0;
      r_fsw      <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (w_accept) begin
      r_valid    <= 1'b1;
      r_ir       <= in_ir;
      r_fcal     <= w_dec_fcal;
      r_fop      <= w_dec_fop;
      r_frd      <= w_dec_frd;
      r_frs1     <= w_dec_frs1;
      r_frs2     <= w_dec_frs2;
      r_regwrite <= w_dec_regwrite;
      r_flw      <= w_dec_flw;
      r_fsw      <= w_dec_fsw;
      r_illegal  <= w_dec_illegal;
    end else if (w_out_fire || flush) begin
      r_valid    <= 1'b0;
    end
  end

  // Scoreboard countdowns: an issuing write reloads its entry, others count down
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NFREG; r++) begin
        r_cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NFREG; r++) begin
        if (w_load_en && (w_load_rd == 5'(r))) begin
          r_cnt[r] <= w_load_lat;
        end else if (r_cnt[r] != '0) begin
          r_cnt[r] <= r_cnt[r] - 1'b1;
        end
      end
    end
  end

  // Busy while counting; done marks the final busy cycle of each entry
  always_comb begin
    for (int r = 0; r < NFREG; r++) begin
      busy_vec[r] = (r_cnt[r] != '0);
      done_vec[r] = (r_cnt[r] == LAT_W'(1));
    end
  end

  assign in_ready     = w_in_ready;
  assign out_valid    = r_valid;
  assign out_ir       = r_ir;
  assign out_fcal     = r_fcal;
  assign out_fop      = r_fop;
  assign out_frd      = r_frd;
  assign out_frs1     = r_frs1;
  assign out_frs2     = r_frs2;
  assign out_regwrite = r_regwrite;
  assign out_flw      = r_flw;
  assign out_fsw      = r_fsw;
  assign out_illegal  = r_illegal;

endmodule

// File: tb/tb_fp_issue_scoreboard.sv
// Directed testbench for fp_issue_scoreboard (default parameters).
module tb_fp_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_ir;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ir;
  logic        out_fcal;
  logic [1:0]  out_fop;
  logic        out_frd;
  logic        out_frs1;
  logic        out_frs2;
  logic        out_regwrite;
  logic        out_flw;
  logic        out_fsw;
  logic        out_illegal;
  logic [31:0] busy_vec;
  logic [31:0] done_vec;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] FADD_F3   = 32'h002081D3; // fadd.s f3,f1,f2
  localparam logic [31:0] FADD_F3B  = 32'h006281D3; // fadd.s f3,f5,f6
  localparam logic [31:0] FMUL_F4   = 32'h10118253; // fmul.s f4,f3,f1
  localparam logic [31:0] FLT_X5    = 32'hA02092D3; // flt.s x5,f1,f2
  localparam logic [31:0] ADDI      = 32'h00100093; // addi x1,x0,1
  localparam logic [31:0] FLW_F7    = 32'h00012387; // flw f7,0(x2)
  localparam logic [31:0] ILL_F3    = 32'hFE0001D3; // OP-FP funct7=1111111

  fp_issue_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_ir        (in_ir),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ir       (out_ir),
    .out_fcal     (out_fcal),
    .out_fop      (out_fop),
    .out_frd      (out_frd),
    .out_frs1     (out_frs1),
    .out_frs2     (out_frs2),
    .out_regwrite (out_regwrite),
    .out_flw      (out_flw),
    .out_fsw      (out_fsw),
    .out_illegal  (out_illegal),
    .busy_vec     (busy_vec),
    .done_vec     (done_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_ir     = FADD_F3;
    out_ready = 1'b0;

    // ---- 1: reset with in_valid high, then first accept
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", busy_vec, 32'd0);
    chk("rst_fop", 32'(out_fop), 32'd3);
    tick();
    chk("rst_out_valid2", 32'(out_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("t1_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_fcal", 32'(out_fcal), 32'd1);
    chk("t1_fop", 32'(out_fop), 32'd0);
    chk("t1_frd", 32'(out_frd), 32'd1);
    chk("t1_ir", out_ir, FADD_F3);

    // ---- 2: RAW on f3 against held FADD and then scoreboard
    in_ir = FMUL_F4;
    #1;
    chk("t2_raw_held", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1;
    chk("t2_raw_held_rdy", 32'(in_ready), 32'd0);
    tick(); // edge k: FADD fires
    chk("t2_k_valid", 32'(out_valid), 32'd0);
    chk("t2_k_busy", busy_vec, 32'h0000_0008);
    chk("t2_k_done", done_vec, 32'd0);
    chk("t2_k_rdy", 32'(in_ready), 32'd0);
    tick(); // k+1
    chk("t2_k1_busy", busy_vec, 32'h0000_0008);
    chk("t2_k1_done", done_vec, 32'd0);
    tick(); // k+2
    chk("t2_k2_busy", busy_vec, 32'h0000_0008);
    chk("t2_k2_done", done_vec, 32'h0000_0008);
    chk("t2_k2_rdy", 32'(in_ready), 32'd0);
    chk("t2_k2_valid", 32'(out_valid), 32'd0);
    tick(); // k+3
    chk("t2_k3_busy", busy_vec, 32'd0);
    chk("t2_k3_done", done_vec, 32'd0);
    chk("t2_k3_rdy", 32'(in_ready), 32'd1);
    chk("t2_k3_valid", 32'(out_valid), 32'd0);
    tick(); // k+4: FMUL accepted
    chk("t2_k4_valid", 32'(out_valid), 32'd1);
    chk("t2_k4_fop", 32'(out_fop), 32'd1);
    chk("t2_k4_ir", out_ir, FMUL_F4);
    in_valid = 1'b0;
    tick(); // FMUL fires, cnt[4]=4
    chk("t2_mul_valid", 32'(out_valid), 32'd0);
    chk("t2_mul_busy", busy_vec, 32'h0000_0010);
    tick();
    tick();
    chk("t2_mul_busy3", busy_vec, 32'h0000_0010);
    chk("t2_mul_done3", done_vec, 32'd0);
    tick();
    chk("t2_mul_done4", done_vec, 32'h0000_0010);
    tick();
    chk("t2_mul_clear", busy_vec, 32'd0);

    // ---- 3: WAW on f3 from held register, then from scoreboard
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ir     = FADD_F3;
    tick();
    chk("t3_held", 32'(out_valid), 32'd1);
    in_ir = FADD_F3B;
    #1;
    chk("t3_waw_held", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1;
    chk("t3_waw_held_rdy", 32'(in_ready), 32'd0);
    tick(); // k: first FADD fires
    chk("t3_k_valid", 32'(out_valid), 32'd0);
    chk("t3_k_rdy", 32'(in_ready), 32'd0);
    tick();
    tick(); // k+2
    chk("t3_k2_rdy", 32'(in_ready), 32'd0);
    tick(); // k+3
    chk("t3_k3_rdy", 32'(in_ready), 32'd1);
    tick(); // k+4
    chk("t3_k4_valid", 32'(out_valid), 32'd1);
    chk("t3_k4_ir", out_ir, FADD_F3B);
    in_valid = 1'b0;
    tick(); // second fires
    chk("t3_busy", busy_vec, 32'h0000_0008);
    tick();
    tick();
    tick();
    chk("t3_clear", busy_vec, 32'd0);

    // ---- 4: FLT.S then back-to-back ADDI
    in_valid = 1'b1;
    in_ir    = FLT_X5;
    tick();
    chk("t4_valid", 32'(out_valid), 32'd1);
    chk("t4_fop", 32'(out_fop), 32'd2);
    chk("t4_frd", 32'(out_frd), 32'd0);
    chk("t4_frs1", 32'(out_frs1), 32'd1);
    chk("t4_regwrite", 32'(out_regwrite), 32'd1);
    in_ir = ADDI;
    #1;
    chk("t4_addi_rdy", 32'(in_ready), 32'd1);
    tick(); // FLT fires, ADDI accepted
    chk("t4_b2b_valid", 32'(out_valid), 32'd1);
    chk("t4_b2b_ir", out_ir, ADDI);
    chk("t4_b2b_fcal", 32'(out_fcal), 32'd0);
    chk("t4_b2b_fop", 32'(out_fop), 32'd3);
    chk("t4_b2b_regwrite", 32'(out_regwrite), 32'd0);
    chk("t4_busy", busy_vec, 32'd0);
    in_valid = 1'b0;
    tick();
    chk("t4_drain", 32'(out_valid), 32'd0);
    chk("t4_busy2", busy_vec, 32'd0);

    // ---- 5: flush with a live FLW countdown
    in_valid = 1'b1;
    in_ir    = FLW_F7;
    tick();
    chk("t5_flw", 32'(out_flw), 32'd1);
    chk("t5_flw_frd", 32'(out_frd), 32'd1);
    in_ir = FADD_F3;
    tick(); // FLW fires (cnt7=2), FADD held
    chk("t5_fadd_held", out_ir, FADD_F3);
    chk("t5_f7_busy", busy_vec, 32'h0000_0080);
    flush = 1'b1;
    in_ir = ADDI;
    #1;
    chk("t5_flush_rdy", 32'(in_ready), 32'd0);
    tick();
    chk("t5_flush_valid", 32'(out_valid), 32'd0);
    chk("t5_flush_busy", busy_vec, 32'h0000_0080);
    chk("t5_flush_done", done_vec, 32'h0000_0080);
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("t5_after_busy", busy_vec, 32'd0);
    chk("t5_after_valid", 32'(out_valid), 32'd0);

    // ---- 6: illegal encoding, then reset mid-countdown
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ir     = ILL_F3;
    tick();
    chk("t6_illegal", 32'(out_illegal), 32'd1);
    chk("t6_ill_fop", 32'(out_fop), 32'd3);
    chk("t6_ill_fcal", 32'(out_fcal), 32'd0);
    chk("t6_ill_rw", 32'(out_regwrite), 32'd0);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    chk("t6_ill_busy", busy_vec, 32'd0);
    in_valid = 1'b1;
    in_ir    = FADD_F3;
    tick();
    in_valid = 1'b0;
    tick(); // fires, cnt3=3
    tick(); // cnt3=2
    chk("t6_pre_rst_busy", busy_vec, 32'h0000_0008);
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", busy_vec, 32'd0);
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_fop", 32'(out_fop), 32'd3);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_no_done", done_vec, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
